// File: rtl/wb_pkg.sv
// Shared writeback-stage encodings: result-select codes and RISC-V load funct3 values.
package wb_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM->WB bundle: M-stage inputs plus pipeline control in, W-stage results out.
interface wb_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              valid_m;
  logic              stall_w;
  logic              flush_w;
  logic              RegWriteM;
  logic [1:0]        ResultSrcM;
  logic [2:0]        funct3M;
  logic [REG_AW-1:0] rdM;
  logic [XLEN-1:0]   PCplus4M;
  logic [XLEN-1:0]   ALUResultM;
  logic [XLEN-1:0]   ReadDataM;
  logic [XLEN-1:0]   ImmExtM;
  logic              valid_w;
  logic              RegWriteW;
  logic [REG_AW-1:0] rdW;
  logic [1:0]        ResultSrcW;
  logic [XLEN-1:0]   ResultW;
  logic              misaligned_w;

  modport master (
    output valid_m, stall_w, flush_w, RegWriteM, ResultSrcM, funct3M, rdM,
           PCplus4M, ALUResultM, ReadDataM, ImmExtM,
    input  valid_w, RegWriteW, rdW, ResultSrcW, ResultW, misaligned_w
  );

  modport slave (
    input  valid_m, stall_w, flush_w, RegWriteM, ResultSrcM, funct3M, rdM,
           PCplus4M, ALUResultM, ReadDataM, ImmExtM,
    output valid_w, RegWriteW, rdW, ResultSrcW, ResultW, misaligned_w
  );
endinterface

// File: rtl/wb_load_ext.sv
// Combinational sub-word load extraction from an aligned memory word, plus natural-alignment check.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFS_W = $clog2(XLEN/8)
) (
  input  logic [2:0]       funct3_i,
  input  logic [OFS_W-1:0] ofs_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [XLEN-1:0]  data_o,
  output logic             unaligned_o
);
  localparam bit IS64 = (XLEN == 64);

  // Addressed byte lands in lane[7:0]; misaligned accesses yield the truncated upper bytes.
  logic [XLEN-1:0] lane;
  assign lane = rdata_i >> {ofs_i, 3'b000};

  always_comb begin
    data_o      = rdata_i;
    unaligned_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = XLEN'($signed(lane[7:0]));
      F3_LBU: data_o = XLEN'(lane[7:0]);
      F3_LH: begin
        data_o      = XLEN'($signed(lane[15:0]));
        unaligned_o = ofs_i[0];
      end
      F3_LHU: begin
        data_o      = XLEN'(lane[15:0]);
        unaligned_o = ofs_i[0];
      end
      F3_LW: begin
        data_o      = XLEN'($signed(lane[31:0]));
        unaligned_o = (ofs_i[1:0] != 2'b00);
      end
      F3_LWU: begin
        if (IS64) begin
          data_o      = XLEN'(lane[31:0]);
          unaligned_o = (ofs_i[1:0] != 2'b00);
        end
      end
      F3_LD: begin
        if (IS64) begin
          data_o      = lane;
          unaligned_o = (ofs_i != '0);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with valid/stall/flush, load extraction and 4-way result mux; 1-cycle latency.
// Optional retired-instruction counter output instret under WB_RETIRE_CNT_EN.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  wb_stage_pipe_if.slave bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]   instret
`endif
);
  localparam int OFS_W = $clog2(XLEN/8);

  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [1:0]        src_q, src_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   imm_q, imm_d;

  // Flush only needs to kill valid; payload fields simply hold.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    src_d      = src_q;
    f3_d       = f3_q;
    pc4_d      = pc4_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    imm_d      = imm_q;
    if (bus.flush_w) begin
      valid_d = 1'b0;
    end else if (!bus.stall_w) begin
      valid_d    = bus.valid_m;
      regwrite_d = bus.RegWriteM;
      rd_d       = bus.rdM;
      src_d      = bus.ResultSrcM;
      f3_d       = bus.funct3M;
      pc4_d      = bus.PCplus4M;
      alu_d      = bus.ALUResultM;
      rdata_d    = bus.ReadDataM;
      imm_d      = bus.ImmExtM;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      src_q      <= RES_ALU;
      f3_q       <= '0;
      pc4_q      <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      src_q      <= src_d;
      f3_q       <= f3_d;
      pc4_q      <= pc4_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      imm_q      <= imm_d;
    end
  end

  logic [XLEN-1:0] load_ext;
  logic            unaligned;
  logic            misaligned;
  logic [XLEN-1:0] result;

  wb_load_ext #(.XLEN(XLEN), .OFS_W(OFS_W)) u_load_ext (
    .funct3_i   (f3_q),
    .ofs_i      (alu_q[OFS_W-1:0]),
    .rdata_i    (rdata_q),
    .data_o     (load_ext),
    .unaligned_o(unaligned)
  );

  assign misaligned = valid_q & (src_q == RES_MEM) & unaligned;

  always_comb begin
    result = alu_q;
    case (src_q)
      RES_ALU: result = alu_q;
      RES_MEM: result = load_ext;
      RES_PC4: result = pc4_q;
      RES_IMM: result = imm_q;
      default: result = alu_q;
    endcase
  end

  assign bus.valid_w      = valid_q;
  assign bus.rdW          = rd_q;
  assign bus.ResultSrcW   = src_q;
  assign bus.ResultW      = result;
  assign bus.misaligned_w = misaligned;
  // x0 is hardwired zero, so a write to it is never requested.
  assign bus.RegWriteW    = valid_q & regwrite_q & (rd_q != '0) & ~misaligned;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (valid_q && !bus.stall_w && !misaligned) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif
endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised writeback stage for the 5-stage RISC-V core. It is the successor to the fixed 32-bit MEM/WB register plus result mux, and adds:
- valid/stall/flush pipeline control;
- sub-word load extraction with sign and zero extension;
- a misalignment flag;
- a fourth result source (immediate).
It sits between the MEM stage and the register file write port. It also drives the forwarding path.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
REG_AW, 5, register address width.
OFS_W, $clog2(XLEN/8), byte-offset width; derived, not overridable.

Ports:
clk  in  1  core clock; rising edge.
reset  in  1  synchronous, active-low reset.
valid_m  in  1  MEM-stage instruction valid.
stall_w  in  1  hold the W register.
flush_w  in  1  kill the instruction entering W.
RegWriteM  in  1  register write request.
ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
funct3M  in  3  load type.
rdM  in  REG_AW  destination register.
PCplus4M  in  XLEN  PC+4.
ALUResultM  in  XLEN  ALU result; low OFS_W bits are the load byte offset.
ReadDataM  in  XLEN  raw aligned memory word.
ImmExtM  in  XLEN  extended immediate (LUI).
valid_w  out  1  W-stage instruction valid.
RegWriteW  out  1  final register-file write enable.
rdW  out  REG_AW  destination register.
ResultSrcW  out  2  registered select.
ResultW  out  XLEN  writeback data.
misaligned_w  out  1  load misalignment detected.

Behaviour:
- Reset (reset==0 at a rising edge): all W registers clear. valid_w=0, RegWriteW=0, rdW=0, ResultSrcW=00, ResultW=0, misaligned_w=0.
- Register update priority at each rising edge with reset==1:
  - flush_w=1: valid register cleared; other fields are don't-care. Flush beats stall.
  - else stall_w=1: all registers hold.
  - else: all M inputs are captured and valid register <= valid_m.
- Latency: 1 cycle from M inputs to W outputs.
- ResultW, RegWriteW and misaligned_w are combinational from W registers only. There is no M-to-W combinational path.
- Result mux: 00 ALUResultW, 01 load_ext, 10 PCplus4W, 11 ImmExtW.
- load_ext (ofs = registered ALUResult[OFS_W-1:0]):
  - 000 LB: byte at ofs, sign-extended. 100 LBU: zero-extended.
  - 001 LH: half at ofs, sign-extended. 101 LHU: zero-extended.
  - 010 LW: word at ofs; sign-extended when XLEN=64.
  - 110 LWU: XLEN=64 only; zero-extended.
  - 011 LD: XLEN=64 only; full word.
  - Any other funct3, or an XLEN-illegal code: raw ReadDataW.
- Misalignment: applies when ResultSrcW==01 and the access is not naturally aligned (half: ofs[0]!=0; word: ofs[1:0]!=0; double: ofs!=0).
  - misaligned_w=valid_w.
  - RegWriteW is forced to 0.
  - ResultW still shows the truncated extraction.
- RegWriteW = valid_w & RegWrite_reg & (rdW!=0) & ~misaligned_w. Writes to x0 are never asserted.
- Stall with flush in the same cycle: the bubble is inserted.
- Reset asserted mid-stall clears the registers regardless of stall_w.

Optional Feature:
WB_RETIRE_CNT_EN
- Defined:
  - Adds output instret (64 bits).
  - instret increments by 1 on every rising edge where valid_w=1, stall_w=0 and misaligned_w=0.
  - It wraps from all-ones to 0.
  - It clears on reset.
- Not defined: the port and the counter are absent; there is no other difference.

Decomposition:
- Package wb_pkg holds:
  - result-select constants RES_ALU, RES_MEM, RES_PC4, RES_IMM;
  - funct3 load constants F3_LB…F3_LWU.
- One sub-module, wb_load_ext: purely combinational extraction, parameters XLEN and OFS_W.
- The pipeline register and the mux stay in the top module.

Test Plan:
1. Reset held low 2 cycles, then released; inputs all idle → all outputs 0 at the first high-reset edge.
2. valid_m=1, RegWriteM=1, rdM=3, ResultSrcM=00, ALUResultM=0x00001010 → next cycle ResultW=0x00001010, RegWriteW=1, rdW=3.
3. ReadDataM=0x80FF7F12, ResultSrcM=01, with load type and offset varied:
   - LB ofs=2 → ResultW=0xFFFFFFFF;
   - LBU ofs=3 → 0x00000080;
   - LH ofs=2 → 0xFFFF80FF;
   - LW ofs=0 → 0x80FF7F12.
4. LH with ALUResultM=0x1001 → misaligned_w=1 and RegWriteW=0.
5. Stall and flush control:
   - stall_w=1 for 3 cycles while the M inputs change → W outputs frozen.
   - stall_w=1 and flush_w=1 together → valid_w=0 and RegWriteW=0 next cycle.
6. With WB_RETIRE_CNT_EN: 5 valid non-stalled instructions, one misaligned → instret=4. rdM=0 with RegWriteM=1 → RegWriteW=0.
